// File: rtl/fp_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_multiplier_seq
// Description : Iterative IEEE-754 single-precision multiplier. Shift-add
//               significand multiply, one partial product per cycle, with a
//               start/done handshake and overflow/underflow/exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_multiplier_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [EXP_W+MANT_W:0]   input1,
    input  logic [EXP_W+MANT_W:0]   input2,
    output logic                    busy,
    output logic                    done,
    output logic [EXP_W+MANT_W:0]   opt,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    exception
);

    localparam int c_W      = 1 + EXP_W + MANT_W;
    localparam int c_SIG_W  = MANT_W + 1;
    localparam int c_PROD_W = 2 * c_SIG_W;
    localparam int c_CNT_W  = $clog2(c_SIG_W);
    localparam int c_SUM_W  = EXP_W + 2;
    localparam int c_BIAS   = 2**(EXP_W-1) - 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MULT = 2'd1;
    localparam logic [1:0] c_ST_NORM = 2'd2;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SIG_W - 1);
    localparam logic [EXP_W-1:0]   c_EXP_ONES = {EXP_W{1'b1}};

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_W-1:0]      r_a;
    logic [c_W-1:0]      r_b;
    logic [c_PROD_W-1:0] r_acc;

    logic [EXP_W-1:0]    w_e1, w_e2;
    logic [c_SIG_W-1:0]  w_sig1, w_sig2;
    logic                w_sign, w_n, w_zero, w_exc_in;
    logic [c_SUM_W-1:0]  w_sum;
    logic [MANT_W-1:0]   w_frac;
    logic [c_W-1:0]      w_opt;
    logic                w_ovf, w_unf, w_exc;

    // Operand decode; a zero exponent drops the hidden bit (denormal).
    assign w_e1     = r_a[c_W-2 -: EXP_W];
    assign w_e2     = r_b[c_W-2 -: EXP_W];
    assign w_sig1   = {|w_e1, r_a[MANT_W-1:0]};
    assign w_sig2   = {|w_e2, r_b[MANT_W-1:0]};
    assign w_sign   = r_a[c_W-1] ^ r_b[c_W-1];
    assign w_zero   = (r_a[c_W-2:0] == '0) || (r_b[c_W-2:0] == '0);
    assign w_exc_in = (w_e1 == c_EXP_ONES) || (w_e2 == c_EXP_ONES);

    // The product of two significands in [1,2) lies in [1,4); n flags [2,4).
    assign w_n    = r_acc[c_PROD_W-1];
    assign w_sum  = c_SUM_W'(w_e1) + c_SUM_W'(w_e2) - c_SUM_W'(c_BIAS) + c_SUM_W'(w_n);
    assign w_frac = w_n ? r_acc[c_PROD_W-2 -: MANT_W] : r_acc[c_PROD_W-3 -: MANT_W];

    always_comb begin
        w_opt = {w_sign, {(c_W-1){1'b0}}};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_exc = 1'b0;
        if (w_exc_in) begin
            w_exc = 1'b1;
            w_opt = {w_sign, c_EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
        end else if (w_zero) begin
            w_opt = {w_sign, {(c_W-1){1'b0}}};
        end else if (!w_sum[c_SUM_W-1] && (w_sum >= c_SUM_W'(c_EXP_ONES))) begin
            w_ovf = 1'b1;
            w_opt = {w_sign, c_EXP_ONES, {MANT_W{1'b0}}};
        end else if (w_sum[c_SUM_W-1] || (w_sum == '0)) begin
            w_unf = 1'b1;
            w_opt = {w_sign, {(c_W-1){1'b0}}};
        end else begin
            w_opt = {w_sign, w_sum[EXP_W-1:0], w_frac};
        end
    end

    assign busy = (r_state == c_ST_MULT) || (r_state == c_ST_NORM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            done      <= 1'b0;
            opt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= input1;
                        r_b     <= input2;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ST_MULT;
                    end
                end
                c_ST_MULT: begin
                    if (w_sig2[r_cnt]) begin
                        r_acc <= r_acc + (c_PROD_W'(w_sig1) << r_cnt);
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_NORM;
                    end
                end
                c_ST_NORM: begin
                    opt       <= w_opt;
                    overflow  <= w_ovf;
                    underflow <= w_unf;
                    exception <= w_exc;
                    done      <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_multiplier_seq
// Description : Directed self-checking bench for fp_multiplier_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic        busy, done, overflow, underflow, exception;
    logic [31:0] opt;

    int n_checks = 0;
    int n_pass   = 0;

    fp_multiplier_seq #(.EXP_W(8), .MANT_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .input1    (input1),
        .input2    (input2),
        .busy      (busy),
        .done      (done),
        .opt       (opt),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    always #5 clk = ~clk;

    // Launches one operation and returns the number of edges after the start
    // edge at which done was first seen (limit 40 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clk);
        input1 = a;
        input2 = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({busy, done, opt, overflow, underflow, exception} !== 36'h0)
            $display("FAIL reset_outputs: got busy=%b done=%b opt=%h flags=%b%b%b want all zero",
                     busy, done, opt, overflow, underflow, exception);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        run_op(32'h40000000, 32'h40400000, cyc);
        n_checks++;
        if (cyc !== 25) $display("FAIL done_latency: got %0d edges want 25", cyc);
        else n_pass++;
        n_checks++;
        if (opt !== 32'h40C00000 || {overflow, underflow, exception} !== 3'b000)
            $display("FAIL mul_2x3: got %h flags=%b%b%b want 40c00000 flags=000",
                     opt, overflow, underflow, exception);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || opt !== 32'h40C00000)
            $display("FAIL done_pulse: got done=%b busy=%b opt=%h want 0 0 40c00000", done, busy, opt);
        else n_pass++;
    endtask

    task automatic test_normalize;
        int cyc;
        run_op(32'h3FC00000, 32'h3FC00000, cyc);
        n_checks++;
        if (cyc !== 25 || opt !== 32'h40100000 || {overflow, underflow, exception} !== 3'b000)
            $display("FAIL mul_1p5_sq: got %h cyc=%0d flags=%b%b%b want 40100000 cyc=25 flags=000",
                     opt, cyc, overflow, underflow, exception);
        else n_pass++;
    endtask

    task automatic test_sign_zero;
        int cyc;
        run_op(32'hBF800000, 32'h40000000, cyc);
        n_checks++;
        if (opt !== 32'hC0000000 || {overflow, underflow, exception} !== 3'b000)
            $display("FAIL mul_neg: got %h flags=%b%b%b want c0000000 flags=000",
                     opt, overflow, underflow, exception);
        else n_pass++;
        run_op(32'h00000000, 32'hC0000000, cyc);
        n_checks++;
        if (opt !== 32'h80000000 || {overflow, underflow, exception} !== 3'b000)
            $display("FAIL mul_zero: got %h flags=%b%b%b want 80000000 flags=000",
                     opt, overflow, underflow, exception);
        else n_pass++;
    endtask

    task automatic test_over_under;
        int cyc;
        run_op(32'h7F000000, 32'h7F000000, cyc);
        n_checks++;
        if (opt !== 32'h7F800000 || {overflow, underflow, exception} !== 3'b100)
            $display("FAIL overflow: got %h flags=%b%b%b want 7f800000 flags=100",
                     opt, overflow, underflow, exception);
        else n_pass++;
        run_op(32'h00800000, 32'h00800000, cyc);
        n_checks++;
        if (opt !== 32'h00000000 || {overflow, underflow, exception} !== 3'b010)
            $display("FAIL underflow: got %h flags=%b%b%b want 00000000 flags=010",
                     opt, overflow, underflow, exception);
        else n_pass++;
    endtask

    task automatic test_exception;
        int cyc;
        run_op(32'h7F800000, 32'h3F800000, cyc);
        n_checks++;
        if (opt !== 32'h7FC00000 || {overflow, underflow, exception} !== 3'b001)
            $display("FAIL exception: got %h flags=%b%b%b want 7fc00000 flags=001",
                     opt, overflow, underflow, exception);
        else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int cyc;
        int extra;
        fork
            run_op(32'h40000000, 32'h40400000, cyc);
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                input1 = 32'h3F800000;
                input2 = 32'h3F800000;
                start  = 1'b1;
                @(negedge clk);
                start  = 1'b0;
            end
        join
        n_checks++;
        if (cyc !== 25 || opt !== 32'h40C00000)
            $display("FAIL start_while_busy: got %h cyc=%0d want 40c00000 cyc=25", opt, cyc);
        else n_pass++;
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL single_done: got %0d extra done pulses want 0", extra);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [31:0] mid_opt;
        run_op(32'hBF800000, 32'h40000000, cyc);
        // Still inside the done cycle: this start must be accepted.
        input1 = 32'h3FC00000;
        input2 = 32'h3FC00000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        mid_opt = 32'h0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 12) mid_opt = opt;
        end
        n_checks++;
        if (mid_opt !== 32'hC0000000)
            $display("FAIL opt_hold: got %h during MULT want c0000000", mid_opt);
        else n_pass++;
        n_checks++;
        if (cyc !== 25 || opt !== 32'h40100000)
            $display("FAIL back_to_back: got %h cyc=%0d want 40100000 cyc=25", opt, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        int cyc;
        int seen;
        @(negedge clk);
        input1 = 32'h40000000;
        input2 = 32'h40400000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, opt, overflow, underflow, exception} !== 36'h0)
            $display("FAIL reset_mid_op: got busy=%b done=%b opt=%h flags=%b%b%b want all zero",
                     busy, done, opt, overflow, underflow, exception);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL aborted_no_done: got %0d active cycles want 0", seen);
        else n_pass++;
        run_op(32'h7F000000, 32'h7F000000, cyc);
        n_checks++;
        if (cyc !== 25 || opt !== 32'h7F800000 || {overflow, underflow, exception} !== 3'b100)
            $display("FAIL after_reset: got %h cyc=%0d flags=%b%b%b want 7f800000 cyc=25 flags=100",
                     opt, cyc, overflow, underflow, exception);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_normalize;
        test_sign_zero;
        test_over_under;
        test_exception;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_op;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
